// File: rtl/cnn_pkg.sv
// Shared CNN datapath package.
// Holds the default channel word width and channel count used by conv1_layer
// and the pooling stages, the signed word / channel-vector types, the pooling
// FSM state type and a signed max helper.
package cnn_pkg;

    localparam int CNN_DW = 32;   // default channel word width
    localparam int CNN_CH = 9;    // default channels per pixel beat

    typedef logic signed [CNN_DW-1:0] word_t;
    typedef word_t vec_t [0:CNN_CH-1];

    // FILL: even row, horizontal maxima are parked in the line buffer.
    // EMIT: odd row, line buffer entry is combined with the new pair.
    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pool_state_e;

    // Signed maximum; on a tie both operands are the same value.
    function automatic word_t smax(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer for the 2x2 pooling stage.
// One entry per horizontal pair of a row; each entry holds the horizontal
// maxima of all channels packed into one word. Write is synchronous; read is
// combinational on the same (write-side) address, so the odd row can combine
// the stored even-row value with the current pair in the same cycle.
// Moving this to a registered-read BRAM needs a matching delay on the
// hold/hmax path in the parent.
//
// Ports:
//   clk      - clock
//   we_i     - write enable
//   addr_i   - entry index (column pair)
//   wdata_i  - packed channel maxima to store
//   rdata_o  - packed contents of entry addr_i
module pool_line_buf #(
    parameter int DEPTH = 12,
    parameter int WIDTH = 288,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Not reset: every entry is written on an even row before it is read.
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/maxpool1_layer.sv
// Streaming 2x2 / stride-2 max-pooling stage behind conv1_layer.
// Accepts one raster-order pixel of CH signed channels per valid_in beat (no
// backpressure) and emits one pooled pixel per 2x2 window, registered, one
// cycle after the odd-row/odd-column beat that completes the window.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   valid_in   - pool_in carries a pixel this cycle
//   pool_in    - per-channel conv1 results
//   valid_out  - pool_out carries a pooled pixel this cycle
//   pool_out   - per-channel 2x2 maxima (held while valid_out is low)
//   frame_done - pulses with the last pooled pixel of a frame
module maxpool1_layer
    import cnn_pkg::*;
#(
    parameter int DW   = CNN_DW,
    parameter int CH   = CNN_CH,
    parameter int IN_W = 24,
    parameter int IN_H = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] pool_in   [0:CH-1],
    output logic                 valid_out,
    output logic signed [DW-1:0] pool_out  [0:CH-1],
    output logic                 frame_done
);

    localparam int COL_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W    = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LB_DEPTH = IN_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

    if ((IN_W % 2) != 0) begin : g_bad_in_w
        $error("maxpool1_layer: IN_W must be even");
    end
    if ((IN_H % 2) != 0) begin : g_bad_in_h
        $error("maxpool1_layer: IN_H must be even");
    end

    pool_state_e          state_q;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 valid_out_q;
    logic                 frame_done_q;
    logic signed [DW-1:0] hold_q     [0:CH-1];
    logic signed [DW-1:0] pool_out_q [0:CH-1];

    logic signed [DW-1:0] hmax [0:CH-1];
    logic signed [DW-1:0] vmax [0:CH-1];
    logic [CH*DW-1:0]     lb_wdata;
    logic [CH*DW-1:0]     lb_rdata;
    logic [LB_AW-1:0]     lb_addr;
    logic                 lb_we;
    logic                 row_end;

    // Column pair index; col_q[0] is dropped.
    assign lb_addr = LB_AW'(col_q >> 1);
    assign lb_we   = valid_in && col_q[0] && (state_q == FILL);
    assign row_end = (col_q == COL_LAST);

    always_comb begin
        lb_wdata = '0;
        for (int c = 0; c < CH; c++) begin
            hmax[c] = smax(hold_q[c], pool_in[c]);
            lb_wdata[c*DW +: DW] = hmax[c];
            vmax[c] = smax(lb_rdata[c*DW +: DW], hmax[c]);
        end
    end

    // Raster position after the current beat.
    always_comb begin
        col_d = row_end ? '0 : col_q + COL_W'(1);
        row_d = row_q;
        if (row_end) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end
    end

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .WIDTH (CH*DW),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (lb_we),
        .addr_i  (lb_addr),
        .wdata_i (lb_wdata),
        .rdata_o (lb_rdata)
    );

    // Row-parity FSM with the position counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                hold_q[c]     <= '0;
                pool_out_q[c] <= '0;
            end
        end else begin
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (valid_in) begin
                if (!col_q[0]) begin
                    for (int c = 0; c < CH; c++) begin
                        hold_q[c] <= pool_in[c];
                    end
                end else if (state_q == EMIT) begin
                    for (int c = 0; c < CH; c++) begin
                        pool_out_q[c] <= vmax[c];
                    end
                    valid_out_q  <= 1'b1;
                    frame_done_q <= row_end && (row_q == ROW_LAST);
                end
                col_q <= col_d;
                row_q <= row_d;
                if (row_end) begin
                    state_q <= (state_q == FILL) ? EMIT : FILL;
                end
            end
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign pool_out   = pool_out_q;

endmodule

// File: doc/maxpool1_layer.md
# maxpool1_layer

Streaming 2x2, stride-2 max-pooling stage directly downstream of `conv1_layer`. It takes the per-pixel, 9-channel feature vector that `conv1_layer` emits on `valid_out` / `conv1_out[0:8]`, in raster order. It emits one pooled 9-channel vector per 2x2 window to the next layer. There is no backpressure: the stage must accept a beat on every cycle on which `valid_in` is high.

## Interface
Parameters:
- `DW`, 32: channel word width, two's-complement signed.
- `CH`, 9: channels per beat.
- `IN_W`, 24: feature-map width in pixels. Must be even; elaboration fails otherwise.
- `IN_H`, 32: feature-map height in rows. Must be even; elaboration fails otherwise.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `valid_in`, in, 1: `pool_in` holds one pixel this cycle. Wired to `conv1_layer.valid_out`.
- `pool_in[0:CH-1]`, in, DW each: per-channel conv1 results. Wired to `conv1_out`.
- `valid_out`, out, 1: `pool_out` holds one pooled pixel this cycle.
- `pool_out[0:CH-1]`, out, DW each: per-channel 2x2 maxima.
- `frame_done`, out, 1: one-cycle pulse together with the last pooled pixel of a frame.

## Operation
- Counters:
  - `col` runs 0..IN_W-1 and `row` runs 0..IN_H-1.
  - Both advance only on cycles where `valid_in` is high.
  - `col` wraps to 0 after IN_W-1, and `row` increments on that wrap.
  - `row` wraps to 0 after IN_H-1, so the next frame needs no reset.
- Horizontal stage:
  - On even `col`, latch `pool_in` into `hold[0:CH-1]`.
  - On odd `col`, form `hmax[c] = max(hold[c], pool_in[c])` for every channel.
- Even `row`, odd `col`: write `hmax` into line buffer entry `col>>1`. The buffer is IN_W/2 entries of CH*DW bits.
- Odd `row`, odd `col`:
  - Compute `vmax[c] = max(linebuf[col>>1][c], hmax[c])`.
  - Register `vmax` onto `pool_out` and assert `valid_out`.
- All comparisons are signed, full DW width, with no saturation or truncation. On a tie, either operand may be taken (the value is identical).
- FSM, two states:
  - `FILL` (even row) and `EMIT` (odd row).
  - Reset enters `FILL`.
  - The transition happens on the valid beat that completes a row (`col == IN_W-1`), toggling between the two states.
  - `EMIT`→`FILL` on the last row also wraps `row`.
- Gaps: `valid_in` low for any number of cycles freezes all state. `hold` and the line buffer are retained across gaps.
- Output rate: IN_W/2 × IN_H/2 pooled pixels per frame, which is 12×16 = 192 with default parameters.

## Timing
- Latency: `valid_out` is high exactly one cycle after the accepted beat at an odd `row` and odd `col`. At all other times it is low.
- `pool_out` holds its last value while `valid_out` is low.
- `frame_done` is high in the same cycle as `valid_out` for the window at `row = IN_H-1`, `col = IN_W-1`. It is low at all other times.
- Reset values:
  - `valid_out` = 0, `frame_done` = 0, `pool_out` = all 0.
  - `col` = 0, `row` = 0, state = `FILL`, `hold` = 0.
  - Line buffer contents are not reset: they are always written before they are read.
- Reset asserted mid-frame:
  - The output registers clear asynchronously.
  - The next accepted beat after reset deasserts is treated as pixel (0,0).
  - No output is produced from data accepted before the reset.
- Back-to-back frames: pixel (0,0) of frame N+1 may arrive on the cycle immediately after the last pixel of frame N. The `frame_done` and `valid_out` pulses for frame N still appear on that cycle.

## Structure
- Shared package `cnn_pkg`:
  - `DW` and `CH` defaults.
  - `typedef logic signed [DW-1:0] word_t`.
  - `typedef word_t vec_t [0:CH-1]`.
  - Function `smax(word_t a, word_t b)`.
  - `conv1_layer` and later layers import it too.
- Sub-module `pool_line_buf`:
  - Simple dual-port register array, IN_W/2 × CH*DW.
  - Synchronous write; combinational read on the write-side address `col>>1`.
  - Separated so it can later be mapped to BRAM with a one-cycle read. If that change is made, the `hold` path needs a matching pipeline stage.

## Test plan
- Ramp frame:
  - Stimulus: pixel value = row*IN_W + col in all channels, continuous `valid_in`.
  - Required: 192 outputs. The first output equals 25 (the maximum of 0, 1, 24, 25) in every channel. The last equals 767 and coincides with the `frame_done` pulse.
- Signed values:
  - Stimulus: window {-5, -3, -7, -1} in channel 0 and {-2147483648, 0, 5, -1} in channel 8.
  - Required: `pool_out[0]` = -1 and `pool_out[8]` = 5.
- Gapped input:
  - Stimulus: the ramp frame with `valid_in` low for a random 0–5 cycles between beats.
  - Required: output values and count are identical to the continuous case. `valid_out` never rises during a gap except one cycle after an odd/odd beat.
- Back-to-back frames:
  - Stimulus: two ramp frames with no idle cycle between them; frame 2 offset by +1000.
  - Required: 384 outputs. Output 193 equals 1025. `frame_done` pulses exactly twice.
- Mid-frame reset:
  - Stimulus: assert `rst` for one cycle after 100 beats, then send a full ramp frame.
  - Required: outputs clear immediately. Exactly 192 correct outputs follow, with no stale window.
- Random compare:
  - Stimulus: 3 frames of `$random` data for all 9 channels.
  - Required: every output matches a scoreboard 2x2 signed-max model.
